alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single 8-bit ALU between two requesters, such as the instruction datapath and a second engine. Each requester hands over an operand/opcode packet with a valid/ready handshake. The block drives the packet onto the ALU inputs and waits a fixed number of cycles for the result to settle. It then captures RESULT/ZERO and returns them on a response port tagged with the requester ID. Only one transaction is in flight at a time.

## Interface
- LAT_CYCLES, default 2: cycles from the ALU inputs being driven to RESULT/ZERO being sampled. Legal range 1..15.
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0_VALID / REQ1_VALID  in  1  requester n presents a packet.
- REQ0_READY / REQ1_READY  out  1  packet accepted when VALID and READY are both high at a rising edge.
- REQ0_DATA1, REQ0_DATA2 / REQ1_DATA1, REQ1_DATA2  in  8  operands.
- REQ0_SELECT / REQ1_SELECT  in  3  ALU opcode.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  1  requester that owns the response.
- RSP_RESULT  out  8  captured ALU RESULT.
- RSP_ZERO  out  1  captured ALU ZERO.
- ALU_DATA1, ALU_DATA2  out  8  registered operands to the ALU.
- ALU_SELECT  out  3  registered opcode to the ALU.
- ALU_RESULT  in  8  ALU RESULT.
- ALU_ZERO  in  1  ALU ZERO.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - REQn_READY is driven combinationally high for the granted requester only.
  - Grant applies only when that requester's VALID is high; at most one READY is high per cycle.
  - On acceptance: latch DATA1/DATA2/SELECT into the ALU_* registers, latch the ID, load the counter with LAT_CYCLES, go to WAIT.
- **WAIT**
  - Counter decrements each cycle. Both READYs are low.
  - When the counter reaches 1: capture ALU_RESULT/ALU_ZERO into RSP_RESULT/RSP_ZERO, go to RESP.
- **RESP**
  - RSP_VALID is high. RSP_ID, RSP_RESULT and RSP_ZERO are held stable until RSP_READY is sampled high.
  - Then: RSP_VALID drops and the FSM returns to IDLE.
- SELECT is passed through unchecked. Reserved codes (101..111) behave as on the ALU.
- No arithmetic in this block; widths are fixed at 8/3 bits.
- ALU_* registers hold the last operands while idle, with no toggling.
- Requests that arrive while the FSM is busy wait with VALID held. A requester must not change its packet while VALID is high and READY is low.

## Timing
- Accept edge = T. ALU_* are valid from T.
- Capture edge = T+LAT_CYCLES. RSP_VALID is high from T+LAT_CYCLES.
- Minimum occupancy: LAT_CYCLES+1 cycles from accept to the response handshake. The next accept is possible one cycle after the response handshake.
- Reset values:
  - State IDLE; RSP_VALID 0; REQn_READY 0.
  - RSP_ID 0; RSP_RESULT 8'h00; RSP_ZERO 0.
  - ALU_DATA1/ALU_DATA2 8'h00; ALU_SELECT 3'b000.
  - Counter 0; round-robin pointer favours REQ0.
- Reset asserted mid-transaction (WAIT or RESP) discards the transaction. No response is ever issued for it.
- LAT_CYCLES=1: capture on the edge after accept, so WAIT lasts one cycle.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin arbitration. When both VALIDs are high in IDLE, grant the requester not granted last.
  - The pointer updates only on an accept.
- ALU_ARB_RR_EN undefined:
  - Fixed priority; REQ0 always wins a tie.
  - REQ1 is granted only when REQ0_VALID is low. The pointer logic is absent.

## Structure
- Shared package alu_arb_pkg holds:
  - State enum (IDLE, WAIT, RESP).
  - Width constants: DATA_W=8, SEL_W=3.
  - Opcode constants: ALU_FWD=3'b000, ALU_ADD=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_J=3'b100.
- One sub-module, alu_arb_grant: combinational 2-way grant logic plus the last-grant pointer register. The macro applies inside it.

## Test plan
- LAT_CYCLES=2; REQ0 ADD 8'd5, 8'd3 at T -> RSP_VALID at T+2, RSP_ID 0, RSP_RESULT 8'd8, RSP_ZERO 0.
- REQ1 ADD 8'h05, 8'hFB -> RSP_RESULT 8'h00, RSP_ZERO 1, RSP_ID 1 (8-bit wrap).
- Both requesters valid continuously for 4 transactions -> with ALU_ARB_RR_EN: RSP_ID sequence 0,1,0,1. Without it: 0,0,0,0.
- RSP_READY held low 5 cycles in RESP -> RSP_* outputs stable, both REQn_READY low, pending REQ1 waits; accepted the cycle after the handshake.
- RESET pulsed low during WAIT -> all outputs return to reset values immediately, no RSP_VALID. The next request after release completes normally with correct result.
- LAT_CYCLES=1; REQ0 OR 8'hF0, 8'h0F -> RSP_VALID one cycle after accept, RSP_RESULT 8'hFF.

Source files
------------

// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Purpose  : Shared types and constants for the two-port ALU arbiter:
//            FSM state encoding, datapath widths, ALU opcode values and the
//            width of the settle-latency counter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    // LAT_CYCLES is limited to 1..15, so four bits hold any load value.
    localparam int CNT_W  = 4;

    localparam logic [SEL_W-1:0] ALU_FWD = 3'b000;
    localparam logic [SEL_W-1:0] ALU_ADD = 3'b001;
    localparam logic [SEL_W-1:0] ALU_AND = 3'b010;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [SEL_W-1:0] ALU_J   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arb_grant.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_grant
// Purpose  : Two-way grant logic for the ALU arbiter. A grant is only ever
//            raised for a requester whose VALID is high, so a grant is also
//            an accept. At most one grant is high per cycle.
//            Macro ALU_ARB_RR_EN: when defined, ties go to the requester not
//            granted last (pointer updates on every accept); when undefined,
//            REQ0 has fixed priority and no pointer register exists.
// Ports    : clk, rst_n          - clock / async active-low reset (RR only)
//            enable              - arbiter is idle and may grant
//            req0_valid/req1_valid - requester packet present
//            grant0/grant1       - combinational grant (drives REQn_READY)
// Revision : 1.0 - initial release
// ============================================================================
module alu_arb_grant (
`ifdef ALU_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic enable,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic grant0,
    output logic grant1
);

`ifdef ALU_ARB_RR_EN
    // High when the most recent accept went to REQ1. Resets high so the
    // first tie after reset goes to REQ0.
    logic r_last_grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            if (req0_valid && req1_valid) begin
                grant0 = r_last_grant1;
                grant1 = !r_last_grant1;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant1 <= 1'b1;
        end else if (grant0) begin
            r_last_grant1 <= 1'b0;
        end else if (grant1) begin
            r_last_grant1 <= 1'b1;
        end
    end
`else
    always_comb begin
        grant0 = enable && req0_valid;
        grant1 = enable && req1_valid && !req0_valid;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one 8-bit ALU between two requesters. An accepted packet
//            is registered onto the ALU inputs, the block waits LAT_CYCLES
//            for the ALU to settle, captures RESULT/ZERO and presents them on
//            the response port tagged with the owning requester ID. One
//            transaction is in flight at a time.
//            Macro ALU_ARB_RR_EN selects round-robin (defined) or fixed REQ0
//            priority (undefined) arbitration inside alu_arb_grant.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            reqN_valid/ready/data1/data2/select - requester N packet port
//            rsp_valid/ready/id/result/zero  - response port
//            alu_data1/data2/select          - registered ALU operands
//            alu_result/alu_zero             - ALU outputs
// Params   : LAT_CYCLES (1..15) - edges from accept to result capture
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int LAT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data1,
    input  logic [DATA_W-1:0] req0_data2,
    input  logic [SEL_W-1:0]  req0_select,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data1,
    input  logic [DATA_W-1:0] req1_data2,
    input  logic [SEL_W-1:0]  req1_select,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,

    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [SEL_W-1:0]  alu_select,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    localparam logic [CNT_W-1:0] c_lat_load = CNT_W'(LAT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic               w_capture;

    alu_arb_grant u_grant (
`ifdef ALU_ARB_RR_EN
        .clk        (clk),
        .rst_n      (rst_n),
`endif
        .enable     (r_state == IDLE),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant0     (w_grant0),
        .grant1     (w_grant1)
    );

    // Grants are only raised with VALID high, so any grant is an accept.
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_accept   = w_grant0 || w_grant1;
    assign w_capture  = (r_state == WAIT) && (r_cnt == CNT_W'(1));
    assign rsp_valid  = (r_state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = WAIT;
            WAIT:    if (w_capture) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ALU operand registers only load on accept, so they hold the last
    // packet while idle and the ALU inputs do not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_select <= '0;
            rsp_id     <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            alu_data1  <= w_grant1 ? req1_data1  : req0_data1;
            alu_data2  <= w_grant1 ? req1_data2  : req0_data2;
            alu_select <= w_grant1 ? req1_select : req0_select;
            rsp_id     <= w_grant1;
            r_cnt      <= c_lat_load;
        end else if (r_state == WAIT) begin
            r_cnt      <= r_cnt - CNT_W'(1);
        end
    end

    // Response fields change only at capture, so they stay stable through
    // any RSP_READY backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (w_capture) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. A LAT_CYCLES=2 instance
//            runs a table of single transactions plus backpressure,
//            arbitration-tie and mid-transaction reset sequences; a
//            LAT_CYCLES=1 instance checks the short-latency case. A small
//            behavioural ALU drives ALU_RESULT/ALU_ZERO for each instance.
//            Honours ALU_ARB_RR_EN for the expected tie-break order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // LAT_CYCLES = 2 instance
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_data1, req0_data2, req1_data1, req1_data2;
    logic [2:0] req0_select, req1_select;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [7:0] rsp_result;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic [2:0] alu_select;
    logic       alu_zero;

    // LAT_CYCLES = 1 instance
    logic       l1_req0_valid, l1_req0_ready, l1_req1_valid, l1_req1_ready;
    logic [7:0] l1_req0_data1, l1_req0_data2, l1_req1_data1, l1_req1_data2;
    logic [2:0] l1_req0_select, l1_req1_select;
    logic       l1_rsp_valid, l1_rsp_ready, l1_rsp_id, l1_rsp_zero;
    logic [7:0] l1_rsp_result;
    logic [7:0] l1_alu_data1, l1_alu_data2, l1_alu_result;
    logic [2:0] l1_alu_select;
    logic       l1_alu_zero;

    alu_arbiter #(.LAT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data1(req0_data1), .req0_data2(req0_data2), .req0_select(req0_select),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data1(req1_data1), .req1_data2(req1_data2), .req1_select(req1_select),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    alu_arbiter #(.LAT_CYCLES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l1_req0_valid), .req0_ready(l1_req0_ready),
        .req0_data1(l1_req0_data1), .req0_data2(l1_req0_data2), .req0_select(l1_req0_select),
        .req1_valid(l1_req1_valid), .req1_ready(l1_req1_ready),
        .req1_data1(l1_req1_data1), .req1_data2(l1_req1_data2), .req1_select(l1_req1_select),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_id(l1_rsp_id),
        .rsp_result(l1_rsp_result), .rsp_zero(l1_rsp_zero),
        .alu_data1(l1_alu_data1), .alu_data2(l1_alu_data2), .alu_select(l1_alu_select),
        .alu_result(l1_alu_result), .alu_zero(l1_alu_zero)
    );

    // Behavioural ALU: FWD passes DATA1, J passes DATA2, reserved codes give 0.
    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            ALU_FWD: return a;
            ALU_ADD: return a + b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_J:   return b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        alu_result    = alu_f(alu_select, alu_data1, alu_data2);
        alu_zero      = (alu_result == 8'h00);
        l1_alu_result = alu_f(l1_alu_select, l1_alu_data1, l1_alu_data2);
        l1_alu_zero   = (l1_alu_result == 8'h00);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    // Full single transaction on the LAT_CYCLES=2 instance.
    task automatic do_txn(input bit id, input logic [2:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic ez);
        int  n;
        logic rdy;
        if (id) begin
            req1_valid = 1'b1; req1_data1 = a; req1_data2 = b; req1_select = sel;
        end else begin
            req0_valid = 1'b1; req0_data1 = a; req0_data2 = b; req0_select = sel;
        end
        #1;
        n   = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 20) begin
            tick();
            n++;
            rdy = id ? req1_ready : req0_ready;
        end
        chk("accept_ready", rdy, 1);
        tick();
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk("alu_data1", alu_data1, a);
        chk("alu_data2", alu_data2, b);
        chk("alu_select", alu_select, sel);
        chk("rsp_valid_wait", rsp_valid, 0);
        wait_rsp(n);
        chk("latency", n, 2);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, er);
        chk("rsp_zero", rsp_zero, ez);
        handshake();
    endtask

    typedef struct {
        bit         id;
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   n;
        logic exp_ids [4];

        vecs[0] = '{1'b0, ALU_ADD, 8'd5,  8'd3,  8'd8,  1'b0};
        vecs[1] = '{1'b1, ALU_ADD, 8'h05, 8'hFB, 8'h00, 1'b1};
        vecs[2] = '{1'b0, ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[3] = '{1'b1, ALU_OR,  8'hA0, 8'h05, 8'hA5, 1'b0};
        vecs[4] = '{1'b0, ALU_FWD, 8'h7E, 8'h11, 8'h7E, 1'b0};
        vecs[5] = '{1'b1, ALU_J,   8'h12, 8'h34, 8'h34, 1'b0};
        vecs[6] = '{1'b0, 3'b111,  8'h9C, 8'h21, 8'h00, 1'b1};

`ifdef ALU_ARB_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        rst_n = 1'b0;
        req0_valid = 0; req0_data1 = 0; req0_data2 = 0; req0_select = 0;
        req1_valid = 0; req1_data1 = 0; req1_data2 = 0; req1_select = 0;
        rsp_ready  = 0;
        l1_req0_valid = 0; l1_req0_data1 = 0; l1_req0_data2 = 0; l1_req0_select = 0;
        l1_req1_valid = 0; l1_req1_data1 = 0; l1_req1_data2 = 0; l1_req1_select = 0;
        l1_rsp_ready  = 0;
        tick();
        tick();

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 8'h00);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_alu_data1", alu_data1, 8'h00);
        chk("rst_alu_data2", alu_data2, 8'h00);
        chk("rst_alu_select", alu_select, 3'b000);
        rst_n = 1'b1;
        tick();

        // Table of single transactions
        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].id, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z);

        // ALU operands hold the last packet while idle
        repeat (3) tick();
        chk("idle_hold_d1", alu_data1, 8'h9C);
        chk("idle_hold_d2", alu_data2, 8'h21);
        chk("idle_hold_sel", alu_select, 3'b111);

        // Backpressure: response held 5 cycles, REQ1 pending meanwhile
        req0_valid = 1; req0_data1 = 8'h01; req0_data2 = 8'h02; req0_select = ALU_ADD;
        #1;
        chk("bp_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_data1 = 8'h0F; req1_data2 = 8'h30; req1_select = ALU_OR;
        #1;
        chk("bp_req1_wait", req1_ready, 0);
        wait_rsp(n);
        chk("bp_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_result", rsp_result, 8'h03);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_rsp_zero", rsp_zero, 0);
            chk("bp_req0_ready_low", req0_ready, 0);
            chk("bp_req1_ready_low", req1_ready, 0);
            tick();
        end
        handshake();
        chk("bp_req1_granted", req1_ready, 1);
        tick();
        req1_valid = 0;
        chk("bp_req1_d1", alu_data1, 8'h0F);
        chk("bp_req1_sel", alu_select, ALU_OR);
        wait_rsp(n);
        chk("bp_req1_latency", n, 2);
        chk("bp_req1_id", rsp_id, 1);
        chk("bp_req1_result", rsp_result, 8'h3F);
        handshake();

        // Tie: both requesters valid for four transactions
        req0_valid = 1; req0_data1 = 8'h10; req0_data2 = 8'h20; req0_select = ALU_ADD;
        req1_valid = 1; req1_data1 = 8'hFF; req1_data2 = 8'h0F; req1_select = ALU_AND;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(n);
            chk("tie_rsp_valid", rsp_valid, 1);
            chk("tie_rsp_id", rsp_id, exp_ids[k]);
            chk("tie_rsp_result", rsp_result, exp_ids[k] ? 8'h0F : 8'h30);
            handshake();
        end
        req0_valid = 0;
        req1_valid = 0;
        repeat (4) tick();

        // Reset during WAIT discards the transaction
        req0_valid = 1; req0_data1 = 8'h01; req0_data2 = 8'h01; req0_select = ALU_ADD;
        #1;
        chk("rw_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_rsp_id", rsp_id, 0);
        chk("rw_rsp_result", rsp_result, 8'h00);
        chk("rw_rsp_zero", rsp_zero, 0);
        chk("rw_alu_data1", alu_data1, 8'h00);
        chk("rw_alu_data2", alu_data2, 8'h00);
        chk("rw_alu_select", alu_select, 3'b000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rw_no_rsp", rsp_valid, 0);
            tick();
        end
        do_txn(1'b1, ALU_ADD, 8'h05, 8'hFB, 8'h00, 1'b1);

        // LAT_CYCLES = 1 instance
        l1_req0_valid = 1; l1_req0_data1 = 8'hF0; l1_req0_data2 = 8'h0F; l1_req0_select = ALU_OR;
        #1;
        chk("l1_req0_ready", l1_req0_ready, 1);
        tick();
        l1_req0_valid = 0;
        chk("l1_rsp_wait", l1_rsp_valid, 0);
        n = 0;
        while (!l1_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("l1_latency", n, 1);
        chk("l1_rsp_result", l1_rsp_result, 8'hFF);
        chk("l1_rsp_zero", l1_rsp_zero, 0);
        chk("l1_rsp_id", l1_rsp_id, 0);
        l1_rsp_ready = 1;
        tick();
        l1_rsp_ready = 0;
        chk("l1_rsp_drop", l1_rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
